cache_arbiter: RTL and testbench

- Shares the single physical-memory line port between the instruction cache and the data cache.
- Sits between both caches' pmem_* interfaces and physical memory.
- Serialises line fills and write-backs, one at a time. Round-robin tie-break.
- Latches each granted request so memory sees stable address, data and opcode for the whole transaction.

---
 rtl/cache_arbiter_pkg.sv | 20 ++
 rtl/cache_arbiter_if.sv | 43 ++++
 rtl/cache_arbiter.sv | 104 ++++++++++
 tb/tb_cache_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the instruction/data cache arbiter in front of physical memory.
package cache_arb_types;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } arb_src_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } pmem_op_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of both caches' pmem ports plus the physical-memory line port.
// The slave view is the arbiter; the master view is whatever drives the caches and memory.
interface cache_arbiter_if #(
   parameter int s_line = 256,
   parameter int s_addr = 32
);
   logic              i_pmem_read;
   logic [s_addr-1:0] i_pmem_address;
   logic [s_line-1:0] i_pmem_rdata;
   logic              i_pmem_resp;

   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [s_addr-1:0] d_pmem_address;
   logic [s_line-1:0] d_pmem_wdata;
   logic [s_line-1:0] d_pmem_rdata;
   logic              d_pmem_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [s_addr-1:0] pmem_address;
   logic [s_line-1:0] pmem_wdata;
   logic [s_line-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      output i_pmem_rdata, i_pmem_resp,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output d_pmem_rdata, d_pmem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      input  i_pmem_rdata, i_pmem_resp,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  d_pmem_rdata, d_pmem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/cache_arbiter.sv
// Serialises I-cache fills and D-cache fills/write-backs onto one memory port,
// round-robin on ties, with the granted request latched for the whole transaction.
module cache_arbiter
   import cache_arb_types::*;
#(
   parameter int s_line = 256,
   parameter int s_addr = 32
) (
   input  logic           clk,
   input  logic           rst,
   cache_arbiter_if.slave bus
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   arb_src_t          r_last_served;
   arb_src_t          w_pick;
   pmem_op_t          r_op;
   logic [s_addr-1:0] r_addr;
   logic [s_line-1:0] r_wdata;
   logic              w_i_req;
   logic              w_d_req;
   logic              w_latch;
   logic              w_done;
   logic              w_grant;

   function automatic arb_src_t rr_pick(input arb_src_t last_served);
      return (last_served == SRC_I) ? SRC_D : SRC_I;
   endfunction

   assign w_i_req = bus.i_pmem_read;
   assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

   // Arbitration decision and state transitions
   always_comb begin
      w_next_state = r_state;
      w_pick       = SRC_I;
      w_latch      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_i_req && w_d_req) begin
               w_pick = rr_pick(r_last_served);
            end else if (w_d_req) begin
               w_pick = SRC_D;
            end else begin
               w_pick = SRC_I;
            end
            if (w_i_req || w_d_req) begin
               w_latch      = 1'b1;
               w_next_state = (w_pick == SRC_D) ? GRANT_D : GRANT_I;
            end else begin
               w_latch      = 1'b0;
            end
         end
         GRANT_I, GRANT_D: begin
            if (bus.pmem_resp) begin
               w_done       = 1'b1;
               w_next_state = IDLE;
            end else begin
               w_done       = 1'b0;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // State, fairness pointer and latched request bank
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_last_served <= SRC_D;
         r_op          <= OP_READ;
         r_addr        <= '0;
         r_wdata       <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_latch && (w_pick == SRC_D)) begin
            r_addr  <= bus.d_pmem_address;
            r_wdata <= bus.d_pmem_wdata;
            r_op    <= bus.d_pmem_write ? OP_WRITE : OP_READ;
         end else if (w_latch) begin
            r_addr  <= bus.i_pmem_address;
            r_op    <= OP_READ;
         end
         if (w_done) begin
            r_last_served <= (r_state == GRANT_D) ? SRC_D : SRC_I;
         end
      end
   end

   // Memory only ever sees the latched copy, never the live cache inputs
   assign w_grant          = (r_state == GRANT_I) || (r_state == GRANT_D);
   assign bus.pmem_read    = w_grant && (r_op == OP_READ);
   assign bus.pmem_write   = w_grant && (r_op == OP_WRITE);
   assign bus.pmem_address = r_addr;
   assign bus.pmem_wdata   = r_wdata;

   assign bus.i_pmem_resp  = (r_state == GRANT_I) && bus.pmem_resp;
   assign bus.d_pmem_resp  = (r_state == GRANT_D) && bus.pmem_resp;
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed plus randomized bench for cache_arbiter; expectations come from a
// transaction-level model of who should be served next and what memory should see.
module tb_cache_arbiter;
   import cache_arb_types::*;

   localparam int SL = 256;
   localparam int SA = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   // model state: who was served last, and what each requester asked for
   bit            m_last_d;
   logic [SA-1:0] m_i_addr;
   logic [SA-1:0] m_d_addr;
   logic [SL-1:0] m_d_wdata;
   bit            m_d_wr;

   always #5 clk = ~clk;

   cache_arbiter_if #(.s_line(SL), .s_addr(SA)) bus ();

   cache_arbiter #(.s_line(SL), .s_addr(SA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [SL-1:0] obs, input logic [SL-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SL-1:0] rand_line();
      logic [SL-1:0] v;
      for (int k = 0; k < SL / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // round-robin rule: on a tie the one not served last wins
   function automatic bit pick_d(input bit ri, input bit rd);
      if (ri && rd) return !m_last_d;
      return rd;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_rd"},    bus.pmem_read,   1'b0);
      chk({tag, "_wr"},    bus.pmem_write,  1'b0);
      chk({tag, "_iresp"}, bus.i_pmem_resp, 1'b0);
      chk({tag, "_dresp"}, bus.d_pmem_resp, 1'b0);
   endtask

   task automatic drive_i(input logic [SA-1:0] a);
      m_i_addr           = a;
      bus.i_pmem_address = a;
      bus.i_pmem_read    = 1'b1;
   endtask

   task automatic drive_d(input logic [SA-1:0] a, input logic [SL-1:0] wd, input int kind);
      m_d_addr           = a;
      m_d_wdata          = wd;
      m_d_wr             = (kind != 0);
      bus.d_pmem_address = a;
      bus.d_pmem_wdata   = wd;
      bus.d_pmem_read    = (kind != 1);
      bus.d_pmem_write   = (kind != 0);
   endtask

   // Entered in the first grant cycle; leaves in the IDLE turnaround cycle.
   task automatic run_txn(input bit is_d, input int lat, input bit keep);
      logic [SA-1:0] ea;
      logic [SL-1:0] rd;
      bit            wr;
      ea = is_d ? m_d_addr : m_i_addr;
      wr = is_d && m_d_wr;
      rd = rand_line();
      for (int c = 0; c <= lat; c++) begin
         chk("grant_read",  bus.pmem_read,    !wr);
         chk("grant_write", bus.pmem_write,   wr);
         chk("grant_addr",  bus.pmem_address, ea);
         if (wr) chk("grant_wdata", bus.pmem_wdata, m_d_wdata);
         chk("early_iresp", bus.i_pmem_resp, 1'b0);
         chk("early_dresp", bus.d_pmem_resp, 1'b0);
         if (c == 0) begin
            if (is_d) begin
               bus.d_pmem_address = 32'hDEAD_BEE0;
               bus.d_pmem_wdata   = rand_line();
            end else begin
               bus.i_pmem_address = $urandom;
            end
         end
         if (c < lat) tick();
      end
      bus.pmem_rdata = rd;
      bus.pmem_resp  = 1'b1;
      #1;
      chk("resp_i",  bus.i_pmem_resp,  !is_d);
      chk("resp_d",  bus.d_pmem_resp,  is_d);
      chk("rdata_i", bus.i_pmem_rdata, rd);
      chk("rdata_d", bus.d_pmem_rdata, rd);
      tick();
      bus.pmem_resp      = 1'b0;
      m_last_d           = is_d;
      bus.i_pmem_address = m_i_addr;
      bus.d_pmem_address = m_d_addr;
      bus.d_pmem_wdata   = m_d_wdata;
      if (!keep) begin
         if (is_d) begin
            bus.d_pmem_read  = 1'b0;
            bus.d_pmem_write = 1'b0;
         end else begin
            bus.i_pmem_read  = 1'b0;
         end
      end
      #1;
      chk_quiet("turnaround");
   endtask

   // Requests are already on the bus in an IDLE cycle; serve until none pending.
   task automatic serve_all(input bit ri, input bit rd, input int lat);
      bit w;
      while (ri || rd) begin
         w = pick_d(ri, rd);
         tick();
         run_txn(w, lat, 1'b0);
         if (w) rd = 1'b0;
         else   ri = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.i_pmem_read    = 1'b0;
      bus.d_pmem_read    = 1'b0;
      bus.d_pmem_write   = 1'b0;
      bus.pmem_resp      = 1'b0;
      tick();
      tick();
      m_last_d = 1'b1;
      chk_quiet("reset");
      chk("reset_addr",  bus.pmem_address, '0);
      chk("reset_wdata", bus.pmem_wdata,   '0);
      rst = 1'b0;
   endtask

   initial begin
      bit ri;
      bit rd;
      int kind;
      bus.i_pmem_read    = 1'b0;
      bus.i_pmem_address = '0;
      bus.d_pmem_read    = 1'b0;
      bus.d_pmem_write   = 1'b0;
      bus.d_pmem_address = '0;
      bus.d_pmem_wdata   = '0;
      bus.pmem_rdata     = '0;
      bus.pmem_resp      = 1'b0;
      m_i_addr  = '0;
      m_d_addr  = '0;
      m_d_wdata = '0;
      m_d_wr    = 1'b0;
      m_last_d  = 1'b1;

      do_reset();

      // lone I fill, long memory latency
      drive_i(32'h0000_1000);
      serve_all(1'b1, 1'b0, 5);

      // lone D write-back
      drive_d(32'h0000_2020, rand_line(), 1);
      serve_all(1'b0, 1'b1, 3);

      // simultaneous first request after reset: I then D
      do_reset();
      drive_i(32'h0000_3000);
      drive_d(32'h0000_4040, rand_line(), 0);
      serve_all(1'b1, 1'b1, 1);

      // both held continuously across four transactions: alternate
      drive_i(32'h0000_5000);
      drive_d(32'h0000_6060, rand_line(), 1);
      for (int t = 0; t < 4; t++) begin
         ri = pick_d(1'b1, 1'b1);
         tick();
         run_txn(ri, 2, 1'b1);
      end
      bus.i_pmem_read  = 1'b0;
      bus.d_pmem_read  = 1'b0;
      bus.d_pmem_write = 1'b0;
      tick();

      // reset in the middle of an I grant, then a stale response
      drive_i(32'h0000_7000);
      tick();
      chk("pre_rst_read", bus.pmem_read, 1'b1);
      rst = 1'b1;
      tick();
      chk_quiet("mid_rst");
      chk("mid_rst_addr", bus.pmem_address, '0);
      rst             = 1'b0;
      bus.i_pmem_read = 1'b0;
      m_last_d        = 1'b1;
      tick();
      bus.pmem_resp = 1'b1;
      #1;
      chk("late_iresp", bus.i_pmem_resp, 1'b0);
      chk("late_dresp", bus.d_pmem_resp, 1'b0);
      tick();
      bus.pmem_resp = 1'b0;
      chk_quiet("after_late");

      // fairness pointer must be back at D, so I wins the tie
      drive_i(32'h0000_8000);
      drive_d(32'h0000_9080, rand_line(), 2);
      serve_all(1'b1, 1'b1, 0);

      // spurious memory response while idle
      bus.pmem_resp = 1'b1;
      #1;
      chk("spur_iresp", bus.i_pmem_resp, 1'b0);
      chk("spur_dresp", bus.d_pmem_resp, 1'b0);
      tick();
      bus.pmem_resp = 1'b0;
      chk_quiet("spur_after");

      // D read and write together: write wins
      drive_d(32'h0000_A0A0, rand_line(), 2);
      serve_all(1'b0, 1'b1, 2);

      // randomized mix
      for (int k = 0; k < 40; k++) begin
         ri   = $urandom_range(0, 1);
         rd   = $urandom_range(0, 1);
         kind = $urandom_range(0, 2);
         if (!ri && !rd) ri = 1'b1;
         if (ri) drive_i($urandom & 32'hFFFF_FFE0);
         if (rd) drive_d($urandom & 32'hFFFF_FFE0, rand_line(), kind);
         serve_all(ri, rd, $urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) begin
            bus.pmem_resp = 1'b1;
            #1;
            chk("rand_spur_i", bus.i_pmem_resp, 1'b0);
            chk("rand_spur_d", bus.d_pmem_resp, 1'b0);
            tick();
            bus.pmem_resp = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
